// File: rtl/alu_pkg.sv
// Shared ALU control codes and arbiter FSM state encoding.
// Imported by the arbiter, its round-robin sub-module and benches.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: one-hot grant from two valids.
// Ports: valid0/valid1 in, last_grant in (1 = req1 won last), grant[1:0] out.
module rr_arb2
  import alu_pkg::*;
(
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case ({valid1, valid0})
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Contention: favour whoever did not win last time.
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters.
// Ports: clk, reset; req0/req1 valid/ready/a/b/ctrl; alu_a/b/ctrl out,
// alu_result/alu_zero in; rsp valid/ready/id/result/zero; busy.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              busy
);

  state_t     state;
  state_t     state_n;
  logic       last_grant;
  logic [1:0] grant;
  logic       take;

  rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign take       = (state == IDLE) && (grant != 2'b00);
  assign req0_ready = take && grant[0] && !reset;
  assign req1_ready = take && grant[1] && !reset;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (take) state_n = EXEC;
      EXEC:    state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operands are latched only on grant, so the ALU drive
  // stays frozen for the whole EXEC/RESP window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            alu_a      <= grant[1] ? req1_a    : req0_a;
            alu_b      <= grant[1] ? req1_b    : req0_b;
            alu_ctrl   <= grant[1] ? req1_ctrl : req0_ctrl;
            rsp_id     <= grant[1];
            last_grant <= grant[1];
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_valid  <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU stub.
// Reports per-check mismatches and one summary line.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic          req0_valid, req0_ready;
  logic [DW-1:0] req0_a, req0_b;
  logic [CW-1:0] req0_ctrl;
  logic          req1_valid, req1_ready;
  logic [DW-1:0] req1_a, req1_b;
  logic [CW-1:0] req1_ctrl;
  logic [DW-1:0] alu_a, alu_b;
  logic [CW-1:0] alu_ctrl;
  logic [DW-1:0] alu_result;
  logic          alu_zero;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [DW-1:0] rsp_result;
  logic          busy;

  int n_chk = 0;
  int n_err = 0;

  alu_arbiter #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ctrl  (req0_ctrl),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ctrl  (req1_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_SLT: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      ALU_NOR: alu_result = ~(alu_a | alu_b);
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step;
    reset = 1'b0;
    step;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int ng;
    int nr;
    reset      = 1'b1;
    req0_valid = 1'b1;
    req0_a     = '0;
    req0_b     = '0;
    req0_ctrl  = '0;
    req1_valid = 1'b0;
    req1_a     = '0;
    req1_b     = '0;
    req1_ctrl  = '0;
    rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, ready blocked while reset is high
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_req0_ready", req0_ready, 0);
    req0_valid = 1'b0;
    reset = 1'b0;
    step;

    // req0 ADD 5+7 alone
    req0_a = 32'd5; req0_b = 32'd7; req0_ctrl = ALU_ADD;
    req0_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("add_r0_ready", req0_ready, 1);
    chk("add_r1_ready", req1_ready, 0);
    step;
    req0_valid = 1'b0;
    chk("add_busy", busy, 1);
    chk("add_exec_valid", rsp_valid, 0);
    chk("add_alu_a", alu_a, 5);
    chk("add_alu_b", alu_b, 7);
    chk("add_alu_ctrl", alu_ctrl, ALU_ADD);
    step;
    chk("add_rsp_valid", rsp_valid, 1);
    chk("add_rsp_id", rsp_id, 0);
    chk("add_rsp_result", rsp_result, 12);
    chk("add_rsp_zero", rsp_zero, 0);
    step;
    chk("add_done_valid", rsp_valid, 0);
    chk("add_done_busy", busy, 0);

    // Both valid from reset: req0 first, then req1
    do_reset;
    req0_a = 32'd9; req0_b = 32'd9; req0_ctrl = ALU_SUB;
    req1_a = 32'hF0; req1_b = 32'h0F; req1_ctrl = ALU_OR;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("both_r0_ready", req0_ready, 1);
    chk("both_r1_ready", req1_ready, 0);
    step;
    req0_valid = 1'b0;
    chk("both_exec_r1_ready", req1_ready, 0);
    step;
    chk("both_rsp0_valid", rsp_valid, 1);
    chk("both_rsp0_id", rsp_id, 0);
    chk("both_rsp0_result", rsp_result, 0);
    chk("both_rsp0_zero", rsp_zero, 1);
    chk("both_resp_r1_ready", req1_ready, 0);
    step;
    chk("both_r1_granted", req1_ready, 1);
    step;
    req1_valid = 1'b0;
    step;
    chk("both_rsp1_valid", rsp_valid, 1);
    chk("both_rsp1_id", rsp_id, 1);
    chk("both_rsp1_result", rsp_result, 32'hFF);
    chk("both_rsp1_zero", rsp_zero, 0);
    step;

    // Six back-to-back contended operations must alternate
    req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = ALU_ADD;
    req1_a = 32'd2; req1_b = 32'd2; req1_ctrl = ALU_ADD;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    ng = 0;
    nr = 0;
    for (int c = 0; c < 40 && nr < 6; c++) begin
      if (req0_ready || req1_ready) begin
        chk("rr_grant", {31'd0, req1_ready}, ng % 2);
        ng++;
      end
      if (rsp_valid) begin
        chk("rr_rsp_id", rsp_id, nr % 2);
        chk("rr_rsp_result", rsp_result, (nr % 2) ? 4 : 2);
        nr++;
      end
      if (nr < 6) step;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_grant_count", ng, 6);
    chk("rr_rsp_count", nr, 6);
    step;
    chk("rr_idle", busy, 0);

    // req1 SLT with back-pressure on the response channel
    req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_ctrl = ALU_SLT;
    req1_valid = 1'b1; rsp_ready = 1'b0;
    #1;
    chk("slt_r1_ready", req1_ready, 1);
    step;
    req1_valid = 1'b0;
    step;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_result", rsp_result, 1);
      chk("hold_id", rsp_id, 1);
      chk("hold_r0_ready", req0_ready, 0);
      chk("hold_r1_ready", req1_ready, 0);
      chk("hold_alu_a", alu_a, 32'hFFFF_FFFF);
      step;
    end
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    step;
    chk("hold_done_valid", rsp_valid, 0);
    chk("hold_done_busy", busy, 0);

    // Async reset while a response is pending
    req1_a = 32'd3; req1_b = 32'd4; req1_ctrl = ALU_ADD;
    req1_valid = 1'b1; rsp_ready = 1'b0;
    step;
    req1_valid = 1'b0;
    step;
    chk("mid_rsp_valid", rsp_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result", rsp_result, 0);
    #2;
    reset = 1'b0;
    req0_a = 32'd5; req0_b = 32'd7; req0_ctrl = ALU_ADD;
    req1_a = 32'd8; req1_b = 32'd1; req1_ctrl = ALU_SUB;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("post_rst_r0_ready", req0_ready, 1);
    chk("post_rst_r1_ready", req1_ready, 0);
    step;
    req0_valid = 1'b0; req1_valid = 1'b0;
    step;
    chk("post_rst_id", rsp_id, 0);
    chk("post_rst_result", rsp_result, 12);
    step;

    // Unsupported control code passes through
    req0_a = 32'd4; req0_b = 32'd4; req0_ctrl = 4'd3;
    req0_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("unsup_r0_ready", req0_ready, 1);
    step;
    req0_valid = 1'b0;
    chk("unsup_alu_ctrl", alu_ctrl, 3);
    step;
    chk("unsup_valid", rsp_valid, 1);
    chk("unsup_result", rsp_result, 0);
    chk("unsup_zero", rsp_zero, 1);
    chk("unsup_id", rsp_id, 0);
    step;
    chk("unsup_done", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter CTRL_W, default 4, ALU control code width.
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0_valid/req1_valid  in  1 each  requester has an operation pending.
REQ-006 SHALL have ports req0_ready/req1_ready  out  1 each  operation accepted this cycle.
REQ-007 SHALL have ports reqN_a, reqN_b  in  DATA_W each; reqN_ctrl  in  CTRL_W  operands and ALU code per requester N.
REQ-008 SHALL have ports alu_a, alu_b  out  DATA_W; alu_ctrl  out  CTRL_W  registered drive to the shared combinational ALU.
REQ-009 SHALL have ports alu_result  in  DATA_W; alu_zero  in  1  ALU outputs.
REQ-010 SHALL have ports rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  1; rsp_result  out  DATA_W; rsp_zero  out  1  response channel.
REQ-011 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-013 In IDLE with any reqN_valid, SHALL grant one requester, assert its reqN_ready combinationally that cycle, latch its a/b/ctrl into alu_a/alu_b/alu_ctrl, latch rsp_id=N, go to EXEC.
REQ-014 reqN_ready SHALL be 0 in EXEC and RESP and for the non-granted requester.
REQ-015 Arbitration SHALL be round-robin on a 1-bit last_grant register: both valid -> grant !last_grant; one valid -> grant it; last_grant updates only on grant.
REQ-016 In EXEC SHALL capture alu_result into rsp_result and alu_zero into rsp_zero, set rsp_valid=1, go to RESP.
REQ-017 In RESP SHALL hold rsp_valid, rsp_id, rsp_result, rsp_zero stable until rsp_ready=1; on that cycle clear rsp_valid and return to IDLE.
REQ-018 Latency: grant at edge T -> rsp_valid high after edge T+2; max throughput one operation per 3 cycles with rsp_ready tied high.
REQ-019 Control codes SHALL pass unmodified; unsupported codes are not filtered (ALU returns 0, zero=1) and SHALL complete normally.
REQ-020 reqN_valid dropping while not granted SHALL be legal and cause no state change.
REQ-021 alu_a/alu_b/alu_ctrl SHALL stay constant from grant until return to IDLE.

Reset
REQ-022 On reset SHALL force state IDLE, last_grant=1 (req0 wins first), rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, alu_a=0, alu_b=0, alu_ctrl=0, busy=0.
REQ-023 Reset mid-operation (EXEC or RESP) SHALL discard the in-flight operation; no response is emitted for it.
REQ-024 reqN_ready SHALL be 0 while reset is asserted.

Structure
REQ-025 ALU control code constants (AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12) and the state enum SHALL live in shared package alu_pkg.
REQ-026 Round-robin grant logic SHALL be sub-module rr_arb2 (inputs two valids + last_grant, outputs one-hot grant); ALU itself stays external.

Verification
REQ-027 req0 ADD a=5 b=7 alone, rsp_ready=1 -> rsp_valid 2 cycles after grant, rsp_id=0, rsp_result=12, rsp_zero=0.
REQ-028 req0 and req1 valid together from reset (req0 SUB 9-9, req1 OR 0xF0|0x0F) -> req0 first: result 0, zero=1; then req1: result 0xFF, id=1.
REQ-029 Both valid continuously for 6 operations -> grants alternate 0,1,0,1,0,1; no starvation.
REQ-030 req1 SLT a=0xFFFFFFFF b=1 with rsp_ready low 5 cycles -> rsp_valid held, result=1 stable; reqN_ready stays 0; completes on rsp_ready.
REQ-031 Reset asserted during RESP -> rsp_valid=0 immediately (async), state IDLE, next grant goes to req0.
REQ-032 req0 ctrl=3 (unsupported) a=4 b=4 -> completes with result 0, zero=1, id=0.
